// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scan/debounce front end.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } kp_state_e;

  localparam int unsigned DEFAULT_SCAN_DIV        = 12000;
  localparam int unsigned DEFAULT_DEBOUNCE_FRAMES = 8;

  // Bits needed to index n items; never less than one bit.
  function automatic int unsigned code_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_col_sync.sv
// Two-flop synchronizer for asynchronous, active-low column inputs; idles high.
module col_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// Row-scanned matrix keypad with frame-level debounce, producing press/release pulses and a held code.
// The release pulse is named key_release because release is a reserved word.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_ROWS        = 4,
  parameter int unsigned NUM_COLS        = 4,
  parameter int unsigned SCAN_DIV        = DEFAULT_SCAN_DIV,
  parameter int unsigned DEBOUNCE_FRAMES = DEFAULT_DEBOUNCE_FRAMES,
  parameter int unsigned CODE_W          = code_w(NUM_ROWS * NUM_COLS)
) (
  input  logic                hwclk,
  input  logic                rst_n,
  output logic [NUM_ROWS-1:0] keypad_row,
  input  logic [NUM_COLS-1:0] keypad_col,
  output logic                press,
  output logic                key_release,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_held,
  output logic                multi_key
);

  localparam int unsigned ROW_W   = code_w(NUM_ROWS);
  localparam int unsigned COL_W   = code_w(NUM_COLS);
  localparam int unsigned DWELL_W = code_w(SCAN_DIV);
  localparam int unsigned CNT_W   = code_w(DEBOUNCE_FRAMES + 1);

  logic [NUM_COLS-1:0] col_sync_n;
  logic [NUM_COLS-1:0] col_act;

  col_sync #(.WIDTH(NUM_COLS)) u_col_sync (
    .clk   (hwclk),
    .rst_n (rst_n),
    .d     (keypad_col),
    .q     (col_sync_n)
  );

  assign col_act = ~col_sync_n;

  logic [DWELL_W-1:0] dwell_d, dwell_q;
  logic [ROW_W-1:0]   row_d, row_q;
  logic               frame_done_d, frame_done_q;
  logic               sample;

  always_comb begin
    dwell_d      = dwell_q + DWELL_W'(1);
    row_d        = row_q;
    sample       = 1'b0;
    frame_done_d = 1'b0;
    if (dwell_q == DWELL_W'(SCAN_DIV - 1)) begin
      dwell_d = '0;
      sample  = 1'b1;
      if (row_q == ROW_W'(NUM_ROWS - 1)) begin
        row_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_comb begin
    keypad_row        = '1;
    keypad_row[row_q] = 1'b0;
  end

  // Lowest active column of the current row, and whether a second one is also active.
  logic             row_hit, row_multi;
  logic [COL_W-1:0] row_col;
  logic [CODE_W-1:0] row_code;

  always_comb begin
    row_hit   = 1'b0;
    row_multi = 1'b0;
    row_col   = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (col_act[c]) begin
        if (row_hit) row_multi = 1'b1;
        else         row_col   = COL_W'(c);
        row_hit = 1'b1;
      end
    end
    row_code = CODE_W'(32'(row_q) * NUM_COLS + 32'(row_col));
  end

  logic              cap_found_d, cap_found_q;
  logic              cap_multi_d, cap_multi_q;
  logic [CODE_W-1:0] cap_code_d, cap_code_q;

  // The capture is consumed on the frame_done cycle and cleared on the same edge.
  always_comb begin
    cap_found_d = cap_found_q;
    cap_multi_d = cap_multi_q;
    cap_code_d  = cap_code_q;
    if (frame_done_q) begin
      cap_found_d = 1'b0;
      cap_multi_d = 1'b0;
      cap_code_d  = '0;
    end else if (sample && row_hit) begin
      if (cap_found_q) cap_multi_d = 1'b1;
      else             cap_code_d  = row_code;
      if (row_multi)   cap_multi_d = 1'b1;
      cap_found_d = 1'b1;
    end
  end

  kp_state_e         state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [CODE_W-1:0] cand_d, cand_q;
  logic [CODE_W-1:0] key_code_d, key_code_q;
  logic              key_held_d, key_held_q;
  logic              press_d, press_q;
  logic              release_d, release_q;
  logic              last_frame;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    key_code_d = key_code_q;
    key_held_d = key_held_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    last_frame = (32'(cnt_q) + 32'd1 >= DEBOUNCE_FRAMES);
    if (frame_done_q) begin
      case (state_q)
        IDLE: if (cap_found_q) begin
          if (DEBOUNCE_FRAMES == 1) begin
            state_d    = HELD;
            press_d    = 1'b1;
            key_code_d = cap_code_q;
            key_held_d = 1'b1;
          end else begin
            state_d = CONFIRM_PRESS;
            cand_d  = cap_code_q;
            cnt_d   = CNT_W'(1);
          end
        end
        CONFIRM_PRESS: begin
          if (!cap_found_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cap_code_q != cand_q) begin
            cand_d = cap_code_q;
            cnt_d  = CNT_W'(1);
          end else if (last_frame) begin
            state_d    = HELD;
            cnt_d      = '0;
            press_d    = 1'b1;
            key_code_d = cand_q;
            key_held_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: if (!cap_found_q) begin
          if (DEBOUNCE_FRAMES == 1) begin
            state_d    = IDLE;
            release_d  = 1'b1;
            key_held_d = 1'b0;
          end else begin
            state_d = CONFIRM_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        CONFIRM_RELEASE: begin
          if (cap_found_q) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (last_frame) begin
            state_d    = IDLE;
            cnt_d      = '0;
            release_d  = 1'b1;
            key_held_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q      <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      cap_found_q  <= 1'b0;
      cap_multi_q  <= 1'b0;
      cap_code_q   <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      cand_q       <= '0;
      key_code_q   <= '0;
      key_held_q   <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      dwell_q      <= dwell_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      cap_found_q  <= cap_found_d;
      cap_multi_q  <= cap_multi_d;
      cap_code_q   <= cap_code_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_code_q   <= key_code_d;
      key_held_q   <= key_held_d;
      press_q      <= press_d;
      release_q    <= release_d;
    end
  end

  assign press       = press_q;
  assign key_release = release_q;
  assign key_code    = key_code_q;
  assign key_held    = key_held_q;
  assign multi_key   = frame_done_q & cap_multi_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench: a physical 4x4 keypad model feeds the scanner; expected pulses are queued with their cycle.
`timescale 1ns/1ps
module tb_keypad_scan_debounce;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_MULTI   = 2;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keypad_row;
  logic [3:0] keypad_col;
  logic       press, key_release, key_held, multi_key;
  logic [3:0] key_code;
  logic [15:0] keys = '0;
  logic [3:0] exp_row;
  int cyc;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int cyc;
    int code;
  } ev_t;
  ev_t evq[$];

  keypad_scan_debounce #(
    .NUM_ROWS        (4),
    .NUM_COLS        (4),
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .hwclk       (hwclk),
    .rst_n       (rst_n),
    .keypad_row  (keypad_row),
    .keypad_col  (keypad_col),
    .press       (press),
    .key_release (key_release),
    .key_code    (key_code),
    .key_held    (key_held),
    .multi_key   (multi_key)
  );

  always #5 hwclk = ~hwclk;

  always @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // A pressed key shorts its column to its row; only the driven-low row pulls a column low.
  always_comb begin
    keypad_col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !keypad_row[r]) keypad_col[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cyc=%0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int code);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.code = code;
    evq.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    tests++;
    if (evq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d code=%0d, want no event", kind, cyc, key_code);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.code != int'(key_code)) begin
        fails++;
        $display("FAIL event: got kind=%0d cyc=%0d code=%0d, want kind=%0d cyc=%0d code=%0d",
                 kind, cyc, key_code, e.kind, e.cyc, e.code);
      end
    end
  endtask

  task automatic at_cycle(input int c);
    int guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge hwclk);
      guard++;
    end
    if (cyc != c) begin
      tests++;
      fails++;
      $display("FAIL at_cycle: got cyc=%0d, want %0d", cyc, c);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_row", keypad_row, 4'b1110);
    check("rst_press", press, 0);
    check("rst_release", key_release, 0);
    check("rst_held", key_held, 0);
    check("rst_multi", multi_key, 0);
    check("rst_code", key_code, 0);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge hwclk);
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_event: got none, want kind=%0d cyc=%0d code=%0d", e.kind, e.cyc, e.code);
      end
      if (press)       check_ev(EV_PRESS);
      if (key_release) check_ev(EV_RELEASE);
      if (multi_key)   check_ev(EV_MULTI);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge hwclk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Idle scan
    for (int k = 0; k < 16; k++) begin
      at_cycle(k);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check("row_scan", keypad_row, exp_row);
    end
    at_cycle(100);
    check("idle_held", key_held, 0);

    // Clean press of code 9
    at_cycle(160);
    keys = 16'h0200;
    push(EV_PRESS, 209, 9);
    at_cycle(208);
    check("held_before_press", key_held, 0);
    at_cycle(209);
    check("held_at_press", key_held, 1);

    // One-frame release glitch, then real release
    at_cycle(240);
    keys = '0;
    push(EV_RELEASE, 321, 9);
    at_cycle(256);
    keys = 16'h0200;
    check("held_glitch", key_held, 1);
    at_cycle(272);
    keys = '0;
    at_cycle(290);
    check("held_confirm_rel", key_held, 1);
    at_cycle(320);
    check("held_before_rel", key_held, 1);
    at_cycle(321);
    check("held_at_rel", key_held, 0);
    check("code_after_rel", key_code, 9);

    // Bouncing key never gets three agreeing frames
    for (int i = 0; i < 8; i++) begin
      at_cycle(327 + 10 * i);
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
    end
    at_cycle(420);
    check("held_after_bounce", key_held, 0);
    check("code_after_bounce", key_code, 9);

    // Two keys: codes 5 and 14
    at_cycle(432);
    keys = 16'h4020;
    push(EV_MULTI, 448, 9);
    push(EV_MULTI, 464, 9);
    push(EV_MULTI, 480, 9);
    push(EV_PRESS, 481, 5);
    push(EV_MULTI, 496, 5);
    push(EV_MULTI, 512, 5);
    at_cycle(482);
    check("held_multi", key_held, 1);
    check("code_multi", key_code, 5);
    at_cycle(512);
    keys = 16'h0020;

    // Reset while held
    at_cycle(530);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    check("queue_before_reset_release", evq.size(), 0);
    repeat (3) @(negedge hwclk);
    rst_n = 1'b1;
    push(EV_PRESS, 49, 5);
    at_cycle(48);
    check("held_post_reset_pre", key_held, 0);
    at_cycle(49);
    check("held_post_reset", key_held, 1);
    at_cycle(64);
    keys = '0;
    push(EV_RELEASE, 113, 5);
    at_cycle(112);
    check("held_pre_rel2", key_held, 1);
    at_cycle(113);
    check("held_rel2", key_held, 0);
    at_cycle(140);
    check("queue_empty", evq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream stage for the keypad FSMs. Scans a row/column matrix keypad by driving one row low at a time and sampling the active-low columns.
- Debounces over whole scan frames and emits a one-cycle press pulse, a one-cycle release pulse and a held key code.
- Replaces the per-column debounced press inputs with a single debounced key event stream, for use by sequence-detector FSMs on the system clock.

Parameters:
- NUM_ROWS, 4, number of driven keypad rows.
- NUM_COLS, 4, number of sensed keypad columns.
- SCAN_DIV, 12000, cycles each row is driven (1 ms at 12 MHz); minimum 4.
- DEBOUNCE_FRAMES, 8, consecutive agreeing frames required to accept a press or release; minimum 1, counter saturates.
- CODE_W, clog2(NUM_ROWS*NUM_COLS), key code width.

Ports:
- hwclk  in  1  system clock (12 MHz).
- rst_n  in  1  reset.
- keypad_row  out  NUM_ROWS  row drives; exactly one bit low, others high.
- keypad_col  in  NUM_COLS  raw column inputs, active low, asynchronous.
- press  out  1  one-cycle pulse when a key press is accepted.
- release  out  1  one-cycle pulse when release of the held key is accepted.
- key_code  out  CODE_W  row*NUM_COLS+col of the last accepted press.
- key_held  out  1  high from the press pulse through the release pulse cycle (exclusive).
- multi_key  out  1  high for one cycle at frame_done when more than one key was seen in that frame.

Interface: one clock; reset is asynchronous and active-low (hwclk, rst_n).

Behaviour:
- Reset values:
  - keypad_row = ~1 (row 0 driven).
  - press, release, key_held, multi_key = 0; key_code = 0.
  - State IDLE; dwell, row and debounce counters = 0; frame capture cleared.
- Column sync: keypad_col passes through 2 flops, reset to all ones. Synced columns are inverted to active-high.
- Row scan:
  - The dwell counter counts 0..SCAN_DIV-1.
  - On its last count, the synced columns are sampled for the current row, then the row index advances modulo NUM_ROWS and keypad_row changes the next cycle.
  - Wrap from row NUM_ROWS-1 to row 0 raises internal frame_done for one cycle, after the last sample.
- Frame capture:
  - Per frame, record the first key found, scanning ascending row then ascending column (lowest code wins), plus an any-key flag and a count-greater-than-1 flag.
  - Capture clears at frame start.
- FSM, evaluated only on frame_done (cnt = debounce counter):
  - IDLE: key found -> CONFIRM_PRESS, cand = code, cnt = 1.
  - CONFIRM_PRESS:
    - no key -> IDLE.
    - different code -> stay, cand = new code, cnt = 1.
    - same code -> cnt+1.
    - When cnt reaches DEBOUNCE_FRAMES -> HELD: press = 1 and key_code = cand (next cycle), key_held = 1.
  - HELD:
    - any key (including a different one) -> stay; no re-press.
    - no key -> CONFIRM_RELEASE, cnt = 1.
  - CONFIRM_RELEASE:
    - any key -> HELD, cnt cleared.
    - no key -> cnt+1.
    - When cnt reaches DEBOUNCE_FRAMES -> IDLE: release = 1, key_held = 0.
- DEBOUNCE_FRAMES = 1: IDLE goes straight to HELD with press. HELD goes straight to IDLE with release. No CONFIRM state is entered.
- Latency: press follows the frame_done of the DEBOUNCE_FRAMES-th matching frame by exactly 1 cycle. The same holds for release.
- key_code holds until the next accepted press; it is not cleared on release.
- Simultaneous press and release pulses are impossible: at most one FSM transition per frame_done.
- multi_key is informational only and does not alter FSM behaviour.
- Reset mid-operation: all state returns to reset values immediately. A pending press is discarded and no release pulse is emitted for a held key.
- Columns are never driven. Undriven rows are high, so pull-ups on the columns are external.

Decomposition:
- Package keypad_pkg:
  - FSM state enum: IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
  - Default SCAN_DIV and DEBOUNCE_FRAMES constants.
  - CODE_W function.
- One sub-module: col_sync, a parameterised-width 2-flop synchronizer with async active-low reset to ones. Everything else is flat.

Test Plan (sim params SCAN_DIV=4, DEBOUNCE_FRAMES=3, 4x4, frame = 16 cycles):
- Reset/scan: release rst_n, no keys -> keypad_row cycles 1110, 1101, 1011, 0111 every 4 cycles; press, release and key_held stay 0 for 10 frames.
- Clean press: hold key row 2/col 1 (column 1 low while row 2 driven) for 5 frames -> exactly one press, 1 cycle after the 3rd frame_done; key_code = 9; key_held = 1.
- Bounce: toggle the same key every 10 cycles for 4 frames, then release -> no press pulse; FSM returns to IDLE.
- Release: after the clean press, release the key -> release pulse 1 cycle after the 3rd empty frame_done. key_held drops with the release pulse and key_code stays 9. A single 1-frame release glitch gives no release.
- Multi-key: hold codes 5 and 14 together -> multi_key pulses each frame; press with key_code = 5.
- Reset mid-hold: assert rst_n low while key_held = 1 -> all outputs 0 asynchronously, no release pulse. Key still held after deassert -> new press 3 frames later.
